// File: rtl/sft_pkg.sv
// Shared constants and helpers for the sliced fine-time classifier.
package sft_pkg;

    localparam logic [7:0]  OFF_CFG     = 8'd0;
    localparam logic [7:0]  OFF_WIN     = 8'd1;

    localparam logic [31:0] CFG_RESET   = 32'hFFFF_FFFF;
    localparam logic [31:0] WIN0_RESET  = 32'hFFFF_FFFF;
    localparam logic [31:0] WIN1_RESET  = 32'h0000_F000;
    localparam logic [31:0] WIN2_RESET  = 32'h0F00_0000;

    function automatic int entry_w(input int nclass, input int cw, input int ntap);
        return nclass + cw + $clog2(ntap);
    endfunction

    function automatic logic [7:0] status_off(input int nclass);
        return 8'(nclass + 1);
    endfunction

    function automatic logic [31:0] win_reset(input int j);
        case (j)
            0:       return WIN0_RESET;
            1:       return WIN1_RESET;
            2:       return WIN2_RESET;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/sft_hit_fifo.sv
// Synchronous first-word-fall-through FIFO holding decoded hit records.
module sft_hit_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && !clr && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;
    assign rdata = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/sfine_time_classifier.sv
// Per-channel fine-time edge decoder, class window matcher and timestamped hit FIFO
// with a small local-bus register file.
module sfine_time_classifier
    import sft_pkg::*;
#(
    parameter int         NTAP       = 32,
    parameter int         RUN        = 3,
    parameter int         NCLASS     = 3,
    parameter int         CW         = 16,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] BASE_ADDR  = 8'h00
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NTAP-1:0]                      tap_in,
    input  logic                                 tap_vld,
    output logic [NCLASS-1:0]                    class_hit,
    output logic                                 hit_vld,
    output logic [$clog2(NTAP)-1:0]              hit_fine,
    input  logic                                 rd_en,
    output logic [NCLASS+CW+$clog2(NTAP)-1:0]    rd_data,
    output logic                                 fifo_empty,
    output logic                                 fifo_full,
    input  logic [31:0]                          DataIn,
    output logic [31:0]                          DataOut,
    input  logic [7:0]                           Address,
    input  logic                                 Read,
    input  logic                                 Write
);

    localparam int         FW         = $clog2(NTAP);
    localparam int         EW         = entry_w(NCLASS, CW, NTAP);
    localparam int         CNTW       = $clog2(FIFO_DEPTH) + 1;
    localparam int         LAST_K     = NTAP - RUN - 2;
    localparam logic [7:0] OFF_STATUS = status_off(NCLASS);

    logic [CW-1:0]     coarse_q, coarse_d;
    logic [NTAP-1:1]   tap0_q, tap0_d;
    logic              vld0_q, vld0_d;
    logic [CW-1:0]     coarse0_q, coarse0_d;
    logic [NTAP-1:0]   dec1_q, dec_d;
    logic [CW-1:0]     coarse1_q, coarse1_d;
    logic [NCLASS-1:0] class_hit_q, class_hit_d;
    logic              hit_vld_q, hit_vld_d;
    logic [FW-1:0]     hit_fine_q, hit_fine_d;
    logic [CW-1:0]     coarse2_q, coarse2_d;
    logic [31:0]       cfg_q, cfg_d;
    logic [31:0]       win_q [NCLASS];
    logic [31:0]       win_d [NCLASS];
    logic [7:0]        ovf_q, ovf_d;

    logic [7:0]        offset;
    logic              fifo_clr;
    logic              drop;
    logic [CNTW-1:0]   fifo_count;
    logic              unused_tap0;

    // Bit 0 of the snapshot can never be part of a decoded edge pattern.
    assign unused_tap0 = tap_in[0];
    assign offset      = Address - BASE_ADDR;
    assign fifo_clr    = cfg_q[31];
    assign drop        = hit_vld_q & fifo_full & ~rd_en & ~fifo_clr;

    for (genvar k = 0; k < NTAP; k++) begin : g_dec
        if (k <= LAST_K) begin : g_edge
            assign dec_d[k] = vld0_q & (&tap0_q[k+RUN:k+1]) & ~tap0_q[k+RUN+1];
        end else begin : g_none
            assign dec_d[k] = 1'b0;
        end
    end

    for (genvar j = 0; j < NCLASS; j++) begin : g_class
        assign class_hit_d[j] = cfg_q[j] & (|(dec1_q & win_q[j][NTAP-1:0]));
    end

    always_comb begin
        coarse_d  = coarse_q + 1'b1;
        tap0_d    = tap_in[NTAP-1:1];
        vld0_d    = tap_vld;
        coarse0_d = coarse_q;
        coarse1_d = coarse0_q;
        coarse2_d = coarse1_q;
        hit_vld_d = |dec1_q;
        hit_fine_d = '0;
        for (int k = NTAP - 1; k >= 0; k--) begin
            if (dec1_q[k]) hit_fine_d = FW'(k);
        end
    end

    // Bit 31 of CFG lives for exactly one cycle and acts as the FIFO clear strobe.
    always_comb begin
        cfg_d = {1'b0, cfg_q[30:0]};
        for (int j = 0; j < NCLASS; j++) win_d[j] = win_q[j];
        ovf_d = ovf_q;
        if (fifo_clr)                    ovf_d = '0;
        else if (drop && ovf_q != 8'hFF) ovf_d = ovf_q + 1'b1;
        if (Write) begin
            if (offset == OFF_CFG) cfg_d = DataIn;
            for (int j = 0; j < NCLASS; j++) begin
                if (offset == OFF_WIN + 8'(j)) win_d[j] = DataIn;
            end
        end
    end

    always_comb begin
        DataOut = '0;
        if (Read) begin
            if (offset == OFF_CFG) DataOut = cfg_q;
            for (int j = 0; j < NCLASS; j++) begin
                if (offset == OFF_WIN + 8'(j)) DataOut = win_q[j];
            end
            if (offset == OFF_STATUS) DataOut = {16'h0, 8'(fifo_count), ovf_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coarse_q    <= '0;
            tap0_q      <= '0;
            vld0_q      <= 1'b0;
            coarse0_q   <= '0;
            dec1_q      <= '0;
            coarse1_q   <= '0;
            class_hit_q <= '0;
            hit_vld_q   <= 1'b0;
            hit_fine_q  <= '0;
            coarse2_q   <= '0;
            cfg_q       <= CFG_RESET;
            for (int j = 0; j < NCLASS; j++) win_q[j] <= win_reset(j);
            ovf_q       <= '0;
        end else begin
            coarse_q    <= coarse_d;
            tap0_q      <= tap0_d;
            vld0_q      <= vld0_d;
            coarse0_q   <= coarse0_d;
            dec1_q      <= dec_d;
            coarse1_q   <= coarse1_d;
            class_hit_q <= class_hit_d;
            hit_vld_q   <= hit_vld_d;
            hit_fine_q  <= hit_fine_d;
            coarse2_q   <= coarse2_d;
            cfg_q       <= cfg_d;
            for (int j = 0; j < NCLASS; j++) win_q[j] <= win_d[j];
            ovf_q       <= ovf_d;
        end
    end

    sft_hit_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (hit_vld_q),
        .pop   (rd_en),
        .wdata ({class_hit_q, coarse2_q, hit_fine_q}),
        .rdata (rd_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign class_hit = class_hit_q;
    assign hit_vld   = hit_vld_q;
    assign hit_fine  = hit_fine_q;

endmodule

// File: tb/tb_sfine_time_classifier.sv
// Directed, table-driven bench for sfine_time_classifier at its default parameters.
module tb_sfine_time_classifier;

    localparam int NTAP = 32, RUN = 3, NCLASS = 3, CW = 16, FIFO_DEPTH = 16;
    localparam int FW = 5, DW = NCLASS + CW + FW;
    localparam logic [7:0] BASE = 8'h00;

    logic              clk;
    logic              rst;
    logic [NTAP-1:0]   tap_in;
    logic              tap_vld;
    logic [NCLASS-1:0] class_hit;
    logic              hit_vld;
    logic [FW-1:0]     hit_fine;
    logic              rd_en;
    logic [DW-1:0]     rd_data;
    logic              fifo_empty;
    logic              fifo_full;
    logic [31:0]       DataIn;
    logic [31:0]       DataOut;
    logic [7:0]        Address;
    logic              Read;
    logic              Write;

    logic [CW-1:0]     model_coarse;
    int                checks;
    int                errors;

    typedef struct {
        logic [31:0] tap;
        logic        exp_vld;
        logic [4:0]  exp_fine;
        logic [2:0]  exp_class;
    } vec_t;

    vec_t vecs [11];

    sfine_time_classifier #(
        .NTAP(NTAP), .RUN(RUN), .NCLASS(NCLASS), .CW(CW),
        .FIFO_DEPTH(FIFO_DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst), .tap_in(tap_in), .tap_vld(tap_vld),
        .class_hit(class_hit), .hit_vld(hit_vld), .hit_fine(hit_fine),
        .rd_en(rd_en), .rd_data(rd_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .DataIn(DataIn), .DataOut(DataOut), .Address(Address), .Read(Read), .Write(Write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference coarse time: counts clock edges since reset was released.
    always @(posedge clk) begin
        if (rst) model_coarse <= '0;
        else     model_coarse <= model_coarse + 1'b1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        Address = a;
        DataIn  = d;
        Write   = 1'b1;
        tick;
        Write   = 1'b0;
        DataIn  = '0;
    endtask

    task automatic bus_read_check(input string name, input logic [7:0] a, input logic [31:0] exp);
        Address = a;
        Read    = 1'b1;
        #1;
        check_output(name, DataOut, exp);
        Read    = 1'b0;
        Address = '0;
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        logic [CW-1:0] ec;
        tap_in  = v.tap;
        tap_vld = 1'b1;
        ec      = model_coarse;
        tick;
        tap_vld = 1'b0;
        tap_in  = '0;
        tick;
        tick;
        check_output($sformatf("v%0d hit_vld", idx), hit_vld, v.exp_vld);
        check_output($sformatf("v%0d hit_fine", idx), hit_fine, v.exp_fine);
        check_output($sformatf("v%0d class_hit", idx), class_hit, v.exp_class);
        tick;
        check_output($sformatf("v%0d hit_vld pulse", idx), hit_vld, 1'b0);
        check_output($sformatf("v%0d fifo_empty", idx), fifo_empty, !v.exp_vld);
        if (v.exp_vld) begin
            check_output($sformatf("v%0d rd_data", idx), rd_data, {v.exp_class, ec, v.exp_fine});
            rd_en = 1'b1;
            tick;
            rd_en = 1'b0;
            check_output($sformatf("v%0d empty after pop", idx), fifo_empty, 1'b1);
        end
    endtask

    initial begin
        logic [CW-1:0] first_c;
        logic [CW-1:0] second_c;
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        tap_in  = '0;
        tap_vld = 1'b0;
        rd_en   = 1'b0;
        DataIn  = '0;
        Address = '0;
        Read    = 1'b0;
        Write   = 1'b0;

        vecs[0]  = '{32'h0000_0F00, 1'b1, 5'd8,  3'b001};
        vecs[1]  = '{32'h0001_E000, 1'b1, 5'd13, 3'b011};
        vecs[2]  = '{32'hF000_0000, 1'b0, 5'd0,  3'b000};
        vecs[3]  = '{32'h0000_0000, 1'b0, 5'd0,  3'b000};
        vecs[4]  = '{32'h0F00_0000, 1'b1, 5'd24, 3'b101};
        vecs[5]  = '{32'h0F00_F000, 1'b1, 5'd12, 3'b111};
        vecs[6]  = '{32'h0000_000E, 1'b1, 5'd0,  3'b001};
        vecs[7]  = '{32'h7000_0000, 1'b1, 5'd27, 3'b101};
        vecs[8]  = '{32'h0000_0600, 1'b0, 5'd0,  3'b000};
        vecs[9]  = '{32'hFFFF_FFFF, 1'b0, 5'd0,  3'b000};
        vecs[10] = '{32'h0000_0007, 1'b0, 5'd0,  3'b000};

        tick;
        tick;
        tick;
        rst = 1'b0;

        // Reset state, read in the first cycle after reset is released.
        bus_read_check("reset CFG", BASE + 8'd0, 32'hFFFF_FFFF);
        bus_read_check("reset WIN1", BASE + 8'd2, 32'h0000_F000);
        bus_read_check("reset WIN2", BASE + 8'd3, 32'h0F00_0000);
        bus_read_check("reset STATUS", BASE + 8'd4, 32'h0);
        check_output("reset fifo_empty", fifo_empty, 1'b1);
        check_output("reset fifo_full", fifo_full, 1'b0);
        check_output("reset hit_vld", hit_vld, 1'b0);
        check_output("reset class_hit", class_hit, 3'b000);
        check_output("reset hit_fine", hit_fine, 5'd0);
        check_output("reset rd_data", rd_data, '0);
        tick;
        bus_read_check("CFG bit31 self-clears", BASE + 8'd0, 32'h7FFF_FFFF);
        bus_read_check("unmapped address", BASE + 8'd5, 32'h0);
        Address = BASE + 8'd1;
        #1;
        check_output("DataOut without Read", DataOut, 32'h0);

        for (int i = 0; i < 11; i++) apply_stimulus(vecs[i], i);

        // Class enable mask: only class 0 remains enabled.
        bus_write(BASE + 8'd0, 32'h0000_0001);
        apply_stimulus('{32'h0001_E000, 1'b1, 5'd13, 3'b001}, 100);
        bus_write(BASE + 8'd0, 32'h0000_0007);
        bus_write(BASE + 8'd2, 32'h0000_0100);
        apply_stimulus('{32'h0000_0F00, 1'b1, 5'd8, 3'b011}, 101);
        bus_read_check("WIN1 readback", BASE + 8'd2, 32'h0000_0100);

        // Seventeen back-to-back hits into a sixteen-entry FIFO.
        first_c = model_coarse;
        for (int i = 0; i < 17; i++) begin
            tap_in  = 32'h0000_0F00;
            tap_vld = 1'b1;
            tick;
        end
        tap_vld = 1'b0;
        tap_in  = '0;
        tick;
        tick;
        tick;
        check_output("overflow fifo_full", fifo_full, 1'b1);
        bus_read_check("overflow STATUS", BASE + 8'd4, 32'h0000_1001);
        check_output("overflow head", rd_data, {3'b011, first_c, 5'd8});

        // Push and pop in the same cycle while full.
        tap_in  = 32'h0000_0F00;
        tap_vld = 1'b1;
        tick;
        tap_vld = 1'b0;
        tap_in  = '0;
        tick;
        tick;
        check_output("full push+pop hit_vld", hit_vld, 1'b1);
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        second_c = first_c + 1'b1;
        bus_read_check("push+pop STATUS", BASE + 8'd4, 32'h0000_1001);
        check_output("push+pop fifo_full", fifo_full, 1'b1);
        check_output("push+pop head", rd_data, {3'b011, second_c, 5'd8});

        // FIFO clear lands in the same cycle as a hit, which must be dropped.
        tap_in  = 32'h0000_0F00;
        tap_vld = 1'b1;
        tick;
        tap_vld = 1'b0;
        tap_in  = '0;
        tick;
        Address = BASE + 8'd0;
        DataIn  = 32'h8000_0007;
        Write   = 1'b1;
        tick;
        Write   = 1'b0;
        DataIn  = '0;
        check_output("clear-cycle hit_vld", hit_vld, 1'b1);
        tick;
        check_output("clear fifo_empty", fifo_empty, 1'b1);
        check_output("clear fifo_full", fifo_full, 1'b0);
        check_output("clear rd_data", rd_data, '0);
        bus_read_check("clear STATUS", BASE + 8'd4, 32'h0);
        bus_read_check("clear CFG", BASE + 8'd0, 32'h0000_0007);

        // Reset while a hit is still in the pipeline.
        tap_in  = 32'h0000_0F00;
        tap_vld = 1'b1;
        tick;
        tap_vld = 1'b0;
        tap_in  = '0;
        rst     = 1'b1;
        tick;
        rst     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check_output($sformatf("mid-reset hit_vld c%0d", i), hit_vld, 1'b0);
        end
        check_output("mid-reset fifo_empty", fifo_empty, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
